// File: rtl/arm_pkg.sv
// Shared types and constants for the LEGv8 front end.
// Opcode extraction fields and the fetch FSM encoding live here.
package arm_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_W   = 11;
    localparam int OPCODE_LSB = 21;
    localparam int PC_INC     = 4;

endpackage

// File: rtl/pc_register.sv
// Program-counter flop: synchronous reset to RESET_PC, loads d when load=1.
module pc_register #(
    parameter int            AW       = 64,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= RESET_PC;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch: one outstanding imem request, single instruction
// register with valid/ready to decode, branch redirect squashing. Optional FETCH_PERF_EN stall counter.
//
// state | meaning
// FETCH | request outstanding at pc, waiting for ack
// HOLD  | instruction register valid, waiting for decode to accept
// DROP  | request in flight is wrong-path; discard its ack, then go to pend_pc
module fetch_unit
    import arm_pkg::*;
#(
    parameter int            AW       = 64,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [AW-1:0]       imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect,
    input  logic [AW-1:0]       redirect_pc,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [AW-1:0]       instr_pc,
    output logic [OPCODE_W-1:0] opcode,
    input  logic                dec_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    fetch_state_t  state;
    logic [AW-1:0] pc;
    logic [AW-1:0] pend_pc;
    logic [AW-1:0] pc_next;
    logic          pc_load;
    logic [AW-1:0] target;

    assign target = redirect_pc & ~AW'(3);

    always_comb begin
        pc_load = 1'b0;
        pc_next = pc;
        unique case (state)
            FETCH: begin
                if (imem_ack && redirect) begin
                    pc_load = 1'b1;
                    pc_next = target;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_load = 1'b1;
                    pc_next = target;
                end else if (dec_ready) begin
                    pc_load = 1'b1;
                    pc_next = instr_pc + AW'(PC_INC);
                end
            end
            DROP: begin
                if (imem_ack) begin
                    pc_load = 1'b1;
                    pc_next = redirect ? target : pend_pc;
                end
            end
            default: begin
                pc_load = 1'b0;
                pc_next = pc;
            end
        endcase
    end

    pc_register #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_next),
        .q     (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pend_pc     <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ack) begin
                        if (!redirect) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (redirect) begin
                        pend_pc <= target;
                        state   <= DROP;
                    end
                end
                HOLD: begin
                    // A redirect squashes the held instruction even if decode is ready.
                    if (redirect || dec_ready) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack)
                        state <= FETCH;
                    else if (redirect)
                        pend_pc <= target;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // pc is not advanced while a wrong-path request is in flight, so it is the DROP address too.
    assign imem_req  = !reset && ((state == FETCH) || (state == DROP));
    assign imem_addr = pc;
    assign opcode    = instr[OPCODE_LSB +: OPCODE_W];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (((imem_req && !imem_ack) || (state == HOLD && !dec_ready))
                 && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with programmable latency,
// scoreboard of expected transfers to decode, plus a wrap-around instance.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic [10:0] opcode;
    logic        dec_ready;

    logic        w_req;
    logic [63:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [63:0] w_instr_pc;
    logic [10:0] w_opcode;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] w_stall;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.AW(64), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .opcode      (opcode),
        .dec_ready   (dec_ready)
`ifdef FETCH_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    fetch_unit #(.AW(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ack    (w_req),
        .imem_rdata  (32'hF840_0000),
        .redirect    (1'b0),
        .redirect_pc (64'h0),
        .instr_valid (w_valid),
        .instr       (w_instr),
        .instr_pc    (w_instr_pc),
        .opcode      (w_opcode),
        .dec_ready   (1'b1)
`ifdef FETCH_PERF_EN
        ,
        .stall_cycles(w_stall)
`endif
    );

    // Memory model: lat wait cycles before ack, counted from the first request cycle.
    int lat = 0;
    int wait_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   return 32'hF840_0000;
            64'h4:   return 32'h8B00_0000;
            64'h100: return 32'hB400_0000;
            default: return 32'h9100_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    assign imem_ack   = imem_req && (wait_cnt == 0);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk) begin
        if (!imem_req || imem_ack)
            wait_cnt <= lat;
        else
            wait_cnt <= wait_cnt - 1;
    end

    typedef struct {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_t;
    exp_t sb[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic expect_xfer(input logic [63:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = mem_word(pc);
        sb.push_back(e);
    endtask

    // Advance one cycle; a transfer to decode in this cycle is scored against the queue.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!reset && instr_valid && dec_ready && !redirect) begin
            if (sb.size() == 0) begin
                chk("unexpected_xfer_pc", instr_pc, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                e = sb.pop_front();
                chk("xfer_pc", instr_pc, e.pc);
                chk("xfer_instr", {32'h0, instr}, {32'h0, e.word});
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] h_instr;
    logic [63:0] h_pc;
    logic [10:0] h_op;

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b1;
        tick();
        tick();
        chk("rst_req", {63'h0, imem_req}, 64'h0);
        chk("rst_valid", {63'h0, instr_valid}, 64'h0);
        chk("rst_instr", {32'h0, instr}, 64'h0);
        chk("rst_instr_pc", instr_pc, 64'h0);
        chk("rst_opcode", {53'h0, opcode}, 64'h0);
`ifdef FETCH_PERF_EN
        chk("rst_stall", {32'h0, stall_cycles}, 64'h0);
`endif

        // 1: zero-wait memory, decode always ready
        reset = 1'b0;
        #1;
        chk("t1_req0", {63'h0, imem_req}, 64'h1);
        chk("t1_addr0", imem_addr, 64'h0);
        chk("t5_addr_reset_pc", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        expect_xfer(64'h0);
        tick();
        chk("t1_valid0", {63'h0, instr_valid}, 64'h1);
        chk("t1_opcode0", {53'h0, opcode}, {53'h0, 11'b111_1100_0010});
        chk("t1_instr_pc0", instr_pc, 64'h0);
        chk("t1_req_hold", {63'h0, imem_req}, 64'h0);
        chk("t5_instr_pc", w_instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_opcode", {53'h0, w_opcode}, {53'h0, 11'b111_1100_0010});
        chk("t5_instr", {32'h0, w_instr}, 64'hF840_0000);
        tick();
        chk("t1_addr1", imem_addr, 64'h4);
        chk("t5_addr_wrap", w_addr, 64'h0);
        chk("t5_req_wrap", {63'h0, w_req}, 64'h1);
        chk("t5_valid_wrap", {63'h0, w_valid}, 64'h0);
        expect_xfer(64'h4);
        tick();
        chk("t1_opcode1", {53'h0, opcode}, {53'h0, 11'b100_0101_1000});
        chk("t1_instr_pc1", instr_pc, 64'h4);

        // 2: backpressure
        dec_ready = 1'b0;
        h_instr = instr;
        h_pc    = instr_pc;
        h_op    = opcode;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_valid", {63'h0, instr_valid}, 64'h1);
            chk("t2_instr", {32'h0, instr}, {32'h0, h_instr});
            chk("t2_instr_pc", instr_pc, h_pc);
            chk("t2_opcode", {53'h0, opcode}, {53'h0, h_op});
            chk("t2_req", {63'h0, imem_req}, 64'h0);
        end
        dec_ready = 1'b1;
        tick();
        chk("t2_next_addr", imem_addr, 64'h8);
        expect_xfer(64'h8);
        tick();

        // 3: three wait cycles, redirect during the second one
        lat = 3;
        tick();
        chk("t3_addr_w0", imem_addr, 64'hC);
        chk("t3_ack_w0", {63'h0, imem_ack}, 64'h0);
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        chk("t3_addr_w1", imem_addr, 64'hC);
        tick();
        redirect = 1'b0;
        chk("t3_addr_w2", imem_addr, 64'hC);
        chk("t3_req_drop", {63'h0, imem_req}, 64'h1);
        tick();
        chk("t3_addr_ack", imem_addr, 64'hC);
        chk("t3_ack", {63'h0, imem_ack}, 64'h1);
        lat = 0;
        tick();
        chk("t3_valid_squash", {63'h0, instr_valid}, 64'h0);
        chk("t3_addr_target", imem_addr, 64'h100);
        tick();
        chk("t3_opcode", {53'h0, opcode}, {53'h0, 11'b101_1010_0000});
        chk("t3_instr_pc", instr_pc, 64'h100);

        // 4: redirect in HOLD beats dec_ready; low address bits are cleared
        redirect    = 1'b1;
        redirect_pc = 64'h203;
        tick();
        redirect = 1'b0;
        chk("t4_valid", {63'h0, instr_valid}, 64'h0);
        chk("t4_addr", imem_addr, 64'h200);
        expect_xfer(64'h200);
        tick();
        lat = 2;
        tick();
        chk("t4_next_addr", imem_addr, 64'h204);
        chk("t4_ack_wait", {63'h0, imem_ack}, 64'h0);

        // 6: reset while in DROP, then while in HOLD
        redirect    = 1'b1;
        redirect_pc = 64'h300;
        tick();
        redirect = 1'b0;
        reset    = 1'b1;
        sb.delete();
        #1;
        chk("t6_req_in_rst_drop", {63'h0, imem_req}, 64'h0);
        tick();
        chk("t6_valid_drop", {63'h0, instr_valid}, 64'h0);
        chk("t6_req_drop", {63'h0, imem_req}, 64'h0);
`ifdef FETCH_PERF_EN
        chk("t6_stall_drop", {32'h0, stall_cycles}, 64'h0);
`endif
        reset = 1'b0;
        #1;
        chk("t6_addr_drop", imem_addr, 64'h0);
        chk("t6_req_after_drop", {63'h0, imem_req}, 64'h1);
        expect_xfer(64'h0);
        tick();
        tick();
        chk("t6_ack_late", {63'h0, imem_ack}, 64'h1);
        lat = 0;
        tick();
        chk("t6_valid_hold", {63'h0, instr_valid}, 64'h1);
        dec_ready = 1'b0;
        reset     = 1'b1;
        sb.delete();
        tick();
        chk("t6_valid_hold_rst", {63'h0, instr_valid}, 64'h0);
        chk("t6_req_hold_rst", {63'h0, imem_req}, 64'h0);
`ifdef FETCH_PERF_EN
        chk("t6_stall_hold", {32'h0, stall_cycles}, 64'h0);
`endif
        reset     = 1'b0;
        dec_ready = 1'b1;
        #1;
        chk("t6_addr_hold", imem_addr, 64'h0);
        expect_xfer(64'h0);
        tick();
        tick();
        tick();
        chk("sb_drained", {32'h0, sb.size()}, 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
